// File: rtl/phy_tx_scheduler.sv
// phy_tx_scheduler
// Shares the byte-wide serializer input between NUM_REQ byte-stream
// requesters. After link enable a comma training run of SYNC_LEN idle symbols
// is sent, then requesters are served round-robin with a per-grant burst
// limit. Empty slots carry IDLE_SYM with valid_stripe=0.
//
// Ports:
//   clk_f        byte clock, rising edge
//   reset_L      asynchronous active-low reset
//   enable       link enable; low forces IDLE
//   resync       single-cycle pulse restarting the training run
//   req          per-requester byte-available flags
//   data_in      flattened requester bytes, requester i at [8i+7:8i]
//   pop          combinational one-hot: byte i consumed at this edge
//   data_stripe  registered byte to the serializer
//   valid_stripe registered; 1 = data byte, 0 = idle symbol
//   grant_id     registered source of the current data_stripe byte
//   link_ready   registered; high while ACTIVE
//   byte_count   (PHY_TX_SCHED_STATS_EN only) saturating data byte count
//   idle_count   (PHY_TX_SCHED_STATS_EN only) saturating ACTIVE idle slot count
//
// Optional feature macro: PHY_TX_SCHED_STATS_EN
//
// state  | meaning
// IDLE   | link disabled, idle symbols, no pops
// SYNC   | comma training, SYNC_LEN idle symbols
// ACTIVE | round-robin service of requesters, link_ready high

module phy_tx_scheduler #(
  parameter int          NUM_REQ   = 4,
  parameter int          BURST_MAX = 4,
  parameter int          SYNC_LEN  = 8,
  parameter logic [7:0]  IDLE_SYM  = 8'hBC,
  localparam int         GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk_f,
  input  logic                   reset_L,
  input  logic                   enable,
  input  logic                   resync,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*8-1:0]   data_in,
  output logic [NUM_REQ-1:0]     pop,
  output logic [7:0]             data_stripe,
  output logic                   valid_stripe,
  output logic [GW-1:0]          grant_id,
  output logic                   link_ready
`ifdef PHY_TX_SCHED_STATS_EN
  ,
  output logic [15:0]            byte_count,
  output logic [15:0]            idle_count
`endif
);

  localparam int SW = $clog2(SYNC_LEN) + 1;
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_LEN - 1);
  localparam logic [BW-1:0] BMAX      = BW'(BURST_MAX);

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    sync_cnt_q, sync_cnt_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic             owner_vld_q, owner_vld_d;
  logic [GW-1:0]    owner_q, owner_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic [GW-1:0]    gid_q, gid_d;
  logic             link_q, link_d;
  logic [NUM_REQ-1:0] pop_c;

  logic             cont;
  logic             win_found;
  logic [GW-1:0]    win_id;

  // Rotating-priority search starting just after the current owner (or at 0
  // when there is none). The owner itself is the last candidate, which gives
  // a bubble-free re-grant when it is the only requester at burst expiry.
  always_comb begin : arb
    int start;
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    start     = 0;
    idx       = 0;
    if (owner_vld_q && (int'(owner_q) < NUM_REQ - 1)) start = int'(owner_q) + 1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (start + k) % NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = GW'(idx);
      end
    end
  end

  assign cont = owner_vld_q && req[owner_q] && (burst_q < BMAX);

  always_comb begin : fsm
    logic [GW-1:0] sel;
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    burst_d     = burst_q;
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    data_d      = IDLE_SYM;
    valid_d     = 1'b0;
    gid_d       = gid_q;
    link_d      = 1'b0;
    pop_c       = '0;
    sel         = cont ? owner_q : win_id;

    if (!enable) begin
      state_d     = ST_IDLE;
      sync_cnt_d  = '0;
      burst_d     = '0;
      owner_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d    = ST_SYNC;
          sync_cnt_d = '0;
        end
        ST_SYNC: begin
          if (resync) begin
            sync_cnt_d = '0;
          end else if (sync_cnt_q == SYNC_LAST) begin
            state_d = ST_ACTIVE;
            link_d  = 1'b1;
          end else begin
            sync_cnt_d = sync_cnt_q + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (resync) begin
            state_d     = ST_SYNC;
            sync_cnt_d  = '0;
            burst_d     = '0;
            owner_vld_d = 1'b0;
          end else begin
            link_d = 1'b1;
            if (cont || win_found) begin
              pop_c[sel] = 1'b1;
              data_d     = data_in[int'(sel)*8 +: 8];
              valid_d    = 1'b1;
              gid_d      = sel;
              owner_vld_d = 1'b1;
              owner_d    = sel;
              burst_d    = cont ? burst_q + 1'b1 : BW'(1);
            end else begin
              owner_vld_d = 1'b0;
              burst_d     = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_IDLE;
      sync_cnt_q  <= '0;
      burst_q     <= '0;
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
      data_q      <= IDLE_SYM;
      valid_q     <= 1'b0;
      gid_q       <= '0;
      link_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      burst_q     <= burst_d;
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      gid_q       <= gid_d;
      link_q      <= link_d;
    end
  end

  assign pop          = pop_c;
  assign data_stripe  = data_q;
  assign valid_stripe = valid_q;
  assign grant_id     = gid_q;
  assign link_ready   = link_q;

`ifdef PHY_TX_SCHED_STATS_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        sync_entry;
  logic        idle_slot;

  // Any transition into SYNC, including a resync that restarts SYNC,
  // starts a fresh statistics window.
  always_comb begin
    sync_entry = enable && ((state_q == ST_IDLE) || (resync && (state_q != ST_IDLE)));
    idle_slot  = enable && !resync && (state_q == ST_ACTIVE) && !(|req);
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    if (sync_entry) begin
      byte_cnt_d = '0;
      idle_cnt_d = '0;
    end else begin
      if (valid_d && (byte_cnt_q != 16'hFFFF)) byte_cnt_d = byte_cnt_q + 16'd1;
      if (idle_slot && (idle_cnt_q != 16'hFFFF)) idle_cnt_d = idle_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign byte_count = byte_cnt_q;
  assign idle_count = idle_cnt_q;
`endif

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Testbench for phy_tx_scheduler (default parameters): a table of directed
// vectors, hand-written corner sequences, then randomized traffic checked
// against a behavioural model of the scheduling rules.

module tb_phy_tx_scheduler;

  localparam int N         = 4;
  localparam int BURST_MAX = 4;
  localparam int SYNC_LEN  = 8;
  localparam logic [7:0] IDLE = 8'hBC;
  localparam logic [31:0] TDATA = 32'hD3C2B1A0;

  logic           clk_f;
  logic           reset_L;
  logic           enable;
  logic           resync;
  logic [N-1:0]   req;
  logic [N*8-1:0] data_in;
  logic [N-1:0]   pop;
  logic [7:0]     data_stripe;
  logic           valid_stripe;
  logic [1:0]     grant_id;
  logic           link_ready;
`ifdef PHY_TX_SCHED_STATS_EN
  logic [15:0]    byte_count;
  logic [15:0]    idle_count;
`endif

  phy_tx_scheduler dut (
    .clk_f        (clk_f),
    .reset_L      (reset_L),
    .enable       (enable),
    .resync       (resync),
    .req          (req),
    .data_in      (data_in),
    .pop          (pop),
    .data_stripe  (data_stripe),
    .valid_stripe (valid_stripe),
    .grant_id     (grant_id),
    .link_ready   (link_ready)
`ifdef PHY_TX_SCHED_STATS_EN
    ,
    .byte_count   (byte_count),
    .idle_count   (idle_count)
`endif
  );

  initial clk_f = 1'b0;
  always #5 clk_f = ~clk_f;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Called right after a falling edge: drive inputs, check the combinational
  // pop, then advance to the next falling edge.
  task automatic step(input logic en, input logic rs, input logic [N-1:0] rq,
                      input logic [31:0] d, input logic [N-1:0] ep, input string nm);
    enable  = en;
    resync  = rs;
    req     = rq;
    data_in = d;
    #1;
    chk({nm, " pop"}, 32'(pop), 32'(ep));
    @(posedge clk_f);
    @(negedge clk_f);
  endtask

  task automatic chk_out(input string nm, input logic ev, input logic [7:0] ed,
                         input logic [1:0] eg, input logic el);
    chk({nm, " valid"}, 32'(valid_stripe), 32'(ev));
    chk({nm, " data"},  32'(data_stripe),  32'(ed));
    chk({nm, " link"},  32'(link_ready),   32'(el));
    if (ev) chk({nm, " grant"}, 32'(grant_id), 32'(eg));
  endtask

  // Behavioural reference: link phase, remaining training symbols, current
  // owner (-1 = none) and bytes already sent in its grant.
  int         m_phase;
  int         m_rem;
  int         m_owner;
  int         m_burst;
  logic [7:0] m_data;
  logic       m_valid;
  int         m_gid;
  logic       m_link;

  task automatic model_init();
    m_phase = 0; m_rem = 0; m_owner = -1; m_burst = 0;
    m_data = IDLE; m_valid = 1'b0; m_gid = 0; m_link = 1'b0;
  endtask

  task automatic model_eval(input logic en, input logic rs, input logic [N-1:0] rq,
                            input logic [31:0] d, output logic [N-1:0] ep);
    int w;
    w  = -1;
    ep = '0;
    m_data  = IDLE;
    m_valid = 1'b0;
    if (!en) begin
      m_phase = 0; m_owner = -1; m_burst = 0; m_link = 1'b0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_rem = SYNC_LEN; m_link = 1'b0;
    end else if (m_phase == 1) begin
      m_link = 1'b0;
      if (rs) m_rem = SYNC_LEN;
      else begin
        m_rem--;
        if (m_rem == 0) begin
          m_phase = 2;
          m_link  = 1'b1;
        end
      end
    end else begin
      if (rs) begin
        m_phase = 1; m_rem = SYNC_LEN; m_owner = -1; m_burst = 0; m_link = 1'b0;
      end else begin
        m_link = 1'b1;
        if (m_owner >= 0 && rq[m_owner] && m_burst < BURST_MAX) begin
          w = m_owner;
          m_burst++;
        end else if (rq != '0) begin
          for (int k = 1; k <= N; k++) begin
            int c;
            c = ((m_owner < 0 ? N - 1 : m_owner) + k) % N;
            if (w < 0 && rq[c]) w = c;
          end
          m_owner = w;
          m_burst = 1;
        end else begin
          m_owner = -1;
          m_burst = 0;
        end
        if (w >= 0) begin
          ep[w]   = 1'b1;
          m_data  = d[w*8 +: 8];
          m_valid = 1'b1;
          m_gid   = w;
        end
      end
    end
  endtask

  typedef struct {
    logic         en;
    logic         rs;
    logic [N-1:0] rq;
    logic [N-1:0] ep;
    logic         ev;
    logic [7:0]   ed;
    logic [1:0]   eg;
    logic         el;
  } vec_t;

  function automatic vec_t mk(logic en, logic rs, logic [N-1:0] rq, logic [N-1:0] ep,
                              logic ev, logic [7:0] ed, logic [1:0] eg, logic el);
    vec_t v;
    v.en = en; v.rs = rs; v.rq = rq; v.ep = ep;
    v.ev = ev; v.ed = ed; v.eg = eg; v.el = el;
    return v;
  endfunction

  function automatic logic [7:0] tbyte(int i);
    return TDATA[i*8 +: 8];
  endfunction

  task automatic do_reset();
    reset_L = 1'b0; enable = 1'b0; resync = 1'b0; req = '0; data_in = '0;
    repeat (2) @(negedge clk_f);
    reset_L = 1'b1;
    model_init();
  endtask

  vec_t tbl[$];

  initial begin
    logic [N-1:0]   ep;
    logic [N-1:0]   rq_cur;
    logic [31:0]    d_cur;
    int             dens;
    logic           en;
    logic           rs;

    // Directed vectors: training run, full-load round robin, owner drop,
    // empty slot, re-arbitration from none, disable.
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 0, IDLE, 0, i == 8));
    for (int k = 0; k < 17; k++)
      tbl.push_back(mk(1, 0, 4'b1111, 4'(1 << ((k / 4) % 4)), 1, tbyte((k / 4) % 4), 2'((k / 4) % 4), 1));
    tbl.push_back(mk(1, 0, 4'b0010, 4'b0010, 1, tbyte(1), 1, 1));
    tbl.push_back(mk(1, 0, 4'b0010, 4'b0010, 1, tbyte(1), 1, 1));
    tbl.push_back(mk(1, 0, 4'b1000, 4'b1000, 1, tbyte(3), 3, 1));
    tbl.push_back(mk(1, 0, 4'b1000, 4'b1000, 1, tbyte(3), 3, 1));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 0, IDLE, 0, 1));
    tbl.push_back(mk(1, 0, 4'b0100, 4'b0100, 1, tbyte(2), 2, 1));
    tbl.push_back(mk(0, 0, 4'b0100, 4'b0000, 0, IDLE, 0, 0));

    do_reset();
    #1;
    chk("reset pop",   32'(pop), 32'h0);
    chk("reset data",  32'(data_stripe), 32'(IDLE));
    chk("reset valid", 32'(valid_stripe), 32'h0);
    chk("reset grant", 32'(grant_id), 32'h0);
    chk("reset link",  32'(link_ready), 32'h0);
    @(negedge clk_f);

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].rs, tbl[i].rq, TDATA, tbl[i].ep, $sformatf("tbl%0d", i));
      chk_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eg, tbl[i].el);
    end

    // Sole requester across burst boundaries: no bubble.
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 4'b0000, 32'h0, 4'b0000, "resync_train");
      chk("train link", 32'(link_ready), 32'(i == 8));
    end
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 4'b0100, {8'h00, 8'(k), 16'h0000}, 4'b0100, $sformatf("solo%0d", k));
      chk_out($sformatf("solo%0d", k), 1, 8'(k), 2, 1);
    end
    step(1, 0, 4'b0000, 32'h0, 4'b0000, "solo_end");
    chk_out("solo_end", 0, IDLE, 0, 1);

    // Resync during a burst.
    step(1, 0, 4'b1111, TDATA, 4'b0001, "pre_rs0");
    step(1, 0, 4'b1111, TDATA, 4'b0001, "pre_rs1");
    step(1, 1, 4'b1111, TDATA, 4'b0000, "resync");
    chk_out("resync", 0, IDLE, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 4'b1111, TDATA, 4'b0000, "rs_sync");
      chk_out("rs_sync", 0, IDLE, 0, i == 7);
    end
    step(1, 0, 4'b1111, TDATA, 4'b0001, "rs_restart");
    chk_out("rs_restart", 1, tbyte(0), 0, 1);

    // Asynchronous reset between edges, mid-burst.
    step(1, 0, 4'b1111, TDATA, 4'b0001, "pre_arst");
    #2;
    reset_L = 1'b0;
    #1;
    chk("arst pop",   32'(pop), 32'h0);
    chk("arst data",  32'(data_stripe), 32'(IDLE));
    chk("arst valid", 32'(valid_stripe), 32'h0);
    chk("arst grant", 32'(grant_id), 32'h0);
    chk("arst link",  32'(link_ready), 32'h0);
    @(negedge clk_f);
    do_reset();

    // Randomized traffic against the reference model.
    rq_cur = '0;
    d_cur  = '0;
    dens   = 2;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 250 == 0) dens = $urandom_range(0, 5);
      en = ($urandom_range(0, 299) != 0);
      rs = ($urandom_range(0, 199) == 0);
      enable = en; resync = rs; req = rq_cur; data_in = d_cur;
      #1;
      model_eval(en, rs, rq_cur, d_cur, ep);
      chk("rand pop", 32'(pop), 32'(ep));
      @(posedge clk_f);
      @(negedge clk_f);
      chk("rand valid", 32'(valid_stripe), 32'(m_valid));
      chk("rand data",  32'(data_stripe),  32'(m_data));
      chk("rand link",  32'(link_ready),   32'(m_link));
      if (m_valid) chk("rand grant", 32'(grant_id), 32'(m_gid));
      for (int i = 0; i < N; i++) begin
        if (!rq_cur[i] || ep[i]) begin
          rq_cur[i] = ($urandom_range(0, 4) < dens);
          d_cur[i*8 +: 8] = 8'($urandom_range(0, 255));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
